mi_sequencer: RTL and testbench
===============================

MI_SEQUENCER -- requirements
Module: mi_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 11, giving the DATA_ADDR width; DATA_ADDR SHALL be instruction[ADDR_W-1:0], with ADDR_W in 5..16.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the instruction buffer entries; it SHALL be a power of two, 2..16.
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port RST, input, width 1: synchronous, active-high reset.
REQ-005 The block SHALL have port instruction, input, width 22: the macro-instruction word.
REQ-006 The block SHALL have port INSTR_VALID, input, width 1: instruction is offered.
REQ-007 The block SHALL have port INSTR_READY, output, width 1: the buffer can accept; it SHALL equal !full.
REQ-008 The block SHALL have port HOLD, input, width 1: sequencer stall.
REQ-009 The block SHALL have port micro_instruction, output, width 33: the registered microword {ALU[3:0],SH[1:0],Kmx,MR,MW,Bus_B[5:0],Bus_C[5:0],T_word[6:0],Bus_A[4:0]}.
REQ-010 The block SHALL have port MI_VALID, output, width 1: micro_instruction is meaningful this cycle.
REQ-011 The block SHALL have port DATA_ADDR, output, width ADDR_W: the operand address of the executing instruction, registered.
REQ-012 The block SHALL have port ILLEGAL, output, width 1: an unrecognised opcode was decoded.
REQ-013 The block SHALL have port BUSY, output, width 1: the sequencer is in state EXEC.

Function
REQ-014 Push: when INSTR_VALID && INSTR_READY, instruction SHALL be written at wr_ptr; pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be held in a $clog2(FIFO_DEPTH)+1-bit counter.
REQ-015 The sequencer SHALL have states IDLE and EXEC, with a step counter of 0..1.
REQ-016 Pop: when HOLD=0, the FIFO is non-empty and (state=IDLE or step is the last step), the head SHALL be popped and decoded, step 0 SHALL be registered, DATA_ADDR SHALL load, and MI_VALID SHALL be 1 on the next cycle.
REQ-017 Latency: an instruction pushed at edge N into an empty, idle block SHALL produce MI_VALID=1 after edge N+1, with no bypass path.
REQ-018 If push and pop occur on the same edge, count SHALL be unchanged; READY SHALL be low when count=FIFO_DEPTH.
REQ-019 If the FIFO is empty at the last step with HOLD=0, the block SHALL go to IDLE, with MI_VALID=0 and micro_instruction at the NOP word.
REQ-020 If HOLD=1, step, state, micro_instruction, DATA_ADDR and MI_VALID SHALL be frozen; pushes SHALL still be accepted.
REQ-021 Any field not listed in the decode table SHALL take its default: Bus_B=100010, Bus_C=100011, all other fields 0.
REQ-022 JUMP, [21:11]=10000000000, SHALL be 1 step with T_word=1000000.
REQ-023 JZE, [21:11]=10100000000, SHALL be 1 step with T_word=1000001.
REQ-024 JCY, [21:11]=11100000000, SHALL be 1 step with T_word=1010000.
REQ-025 STORE, [21:10]=010000000000, SHALL be 2 steps: step0 all defaults (address phase); step1 MW=1, T_word=0000001.
REQ-026 LOAD, [21:10]=010100000000, SHALL be 2 steps: step0 MR=1; step1 T_word=0000010.
REQ-027 ADW, [21:10]=011000000000, SHALL be 1 step: ALU=0101, Bus_C=instruction[9:5] zero-extended, T_word=0111101, Bus_A=instruction[4:0].
REQ-028 MOVK, [21:16]=000100, SHALL be 1 step: Kmx=1, Bus_C=100010, T_word=0000010.
REQ-029 NOP, instruction=22'h3F0000, SHALL be 1 step: ALU=1111, Bus_B=100011, all other fields 0.
REQ-030 Any other encoding SHALL be treated as illegal (see REQ-035/036).

Reset
REQ-031 While RST=1 at an edge, the FIFO SHALL be emptied, state SHALL become IDLE, step=0, MI_VALID=0, BUSY=0, ILLEGAL=0, DATA_ADDR=0 and micro_instruction=NOP word, and INSTR_READY SHALL be 1 the cycle after.
REQ-032 RST SHALL override HOLD and push; a reset mid-2-step instruction SHALL abandon it with no step1 issued.
REQ-033 No storage SHALL rely on initial values.

Configuration
REQ-034 Macro MI_SEQUENCER_ILLEGAL_TRAP_EN SHALL select illegal-opcode handling.
REQ-035 When the macro is defined, an illegal opcode SHALL set ILLEGAL (sticky until RST), issue the NOP word with MI_VALID=0, and block all further pops until RST; pushes SHALL continue until full.
REQ-036 When the macro is undefined, an illegal opcode SHALL execute as a 1-step NOP with MI_VALID=1, and ILLEGAL SHALL be tied 0.

Verification
REQ-037 Push JUMP 22'h200005 into an idle block -> after 2 edges MI_VALID=1, T_word=1000000, DATA_ADDR=5.
REQ-038 LOAD 0x140003 then STORE 0x100007 back-to-back -> 4 consecutive valid words: MR=1; T_word=0000010; defaults; MW=1 with T_word=0000001; DATA_ADDR 3 then 7.
REQ-039 Push FIFO_DEPTH+1 words with HOLD=1 -> READY=0 after the 4th push; release HOLD -> all 4 issue in order and READY returns to 1 after the first pop.
REQ-040 HOLD=1 during step1 of STORE for 3 cycles -> MW=1 word held stable for 3 cycles; simultaneous push+pop leaves count unchanged.
REQ-041 RST=1 during LOAD step0 -> step1 never appears, MI_VALID=0, count=0.
REQ-042 Push 22'h000001 -> with the macro: ILLEGAL=1 sticky and a queued JUMP is not issued; without the macro: NOP issued, ILLEGAL=0, and the following JUMP is issued.

Source files
------------

// File: rtl/mi_sequencer.sv
// Macro-instruction sequencer: queues 22-bit macro-instructions and expands each into 1 or 2 registered 33-bit microwords.
// Optional feature macro: MI_SEQUENCER_ILLEGAL_TRAP_EN (halt with sticky ILLEGAL on an unrecognised opcode).
module mi_sequencer #(
    parameter int ADDR_W     = 11,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [21:0]       instruction,
    input  logic              INSTR_VALID,
    output logic              INSTR_READY,
    input  logic              HOLD,
    output logic [32:0]       micro_instruction,
    output logic              MI_VALID,
    output logic [ADDR_W-1:0] DATA_ADDR,
    output logic              ILLEGAL,
    output logic              BUSY
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    // Microword layout: {ALU[32:29], SH[28:27], Kmx[26], MR[25], MW[24], Bus_B[23:18], Bus_C[17:12], T_word[11:5], Bus_A[4:0]}
    localparam logic [32:0] DEF_WORD = {4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 6'b100010, 6'b100011, 7'b0000000, 5'b00000};
    localparam logic [32:0] NOP_WORD = {4'b1111, 2'b00, 1'b0, 1'b0, 1'b0, 6'b100011, 6'b000000, 7'b0000000, 5'b00000};

    typedef enum logic [3:0] {
        OP_JUMP  = 4'd0,
        OP_JZE   = 4'd1,
        OP_JCY   = 4'd2,
        OP_STORE = 4'd3,
        OP_LOAD  = 4'd4,
        OP_ADW   = 4'd5,
        OP_MOVK  = 4'd6,
        OP_NOP   = 4'd7,
        OP_ILL   = 4'd8
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_e;

    function automatic op_e classify(input logic [21:0] instr);
        op_e op;
        if (instr[21:11] == 11'b10000000000) begin
            op = OP_JUMP;
        end else if (instr[21:11] == 11'b10100000000) begin
            op = OP_JZE;
        end else if (instr[21:11] == 11'b11100000000) begin
            op = OP_JCY;
        end else if (instr[21:10] == 12'b010000000000) begin
            op = OP_STORE;
        end else if (instr[21:10] == 12'b010100000000) begin
            op = OP_LOAD;
        end else if (instr[21:10] == 12'b011000000000) begin
            op = OP_ADW;
        end else if (instr[21:16] == 6'b000100) begin
            op = OP_MOVK;
        end else if (instr == 22'h3F0000) begin
            op = OP_NOP;
        end else begin
            op = OP_ILL;
        end
        return op;
    endfunction

    function automatic logic is_two_step(input op_e op);
        return (op == OP_STORE) || (op == OP_LOAD);
    endfunction

    function automatic logic [32:0] expand(input op_e op, input logic [21:0] instr, input logic step);
        logic [32:0] w;
        w = DEF_WORD;
        case (op)
            OP_JUMP:  w[11:5] = 7'b1000000;
            OP_JZE:   w[11:5] = 7'b1000001;
            OP_JCY:   w[11:5] = 7'b1010000;
            OP_STORE: begin
                // step 0 is the pure address phase and keeps the defaults
                if (step) begin
                    w[24]   = 1'b1;
                    w[11:5] = 7'b0000001;
                end else begin
                    w = DEF_WORD;
                end
            end
            OP_LOAD: begin
                if (step) begin
                    w[11:5] = 7'b0000010;
                end else begin
                    w[25] = 1'b1;
                end
            end
            OP_ADW: begin
                w[32:29] = 4'b0101;
                w[17:12] = {1'b0, instr[9:5]};
                w[11:5]  = 7'b0111101;
                w[4:0]   = instr[4:0];
            end
            OP_MOVK: begin
                w[26]    = 1'b1;
                w[17:12] = 6'b100010;
                w[11:5]  = 7'b0000010;
            end
            OP_NOP:  w = NOP_WORD;
            default: w = NOP_WORD;
        endcase
        return w;
    endfunction

    logic [21:0]       r_mem [FIFO_DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    state_e            r_state;
    logic              r_step;
    op_e               r_op;
    logic [32:0]       r_micro;
    logic              r_mi_valid;
    logic [ADDR_W-1:0] r_data_addr;
`ifdef MI_SEQUENCER_ILLEGAL_TRAP_EN
    logic              r_illegal;
`endif

    logic [21:0] w_head;
    op_e         w_head_op;
    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_at_last;
    logic        w_blocked;
    logic        w_pop;

`ifdef MI_SEQUENCER_ILLEGAL_TRAP_EN
    assign w_blocked = r_illegal;
`else
    assign w_blocked = 1'b0;
`endif

    // Queue status and issue decision
    always_comb begin
        w_head    = r_mem[r_rd_ptr];
        w_head_op = classify(w_head);
        w_empty   = (r_count == {CW{1'b0}});
        w_full    = (r_count == CNT_FULL);
        w_push    = INSTR_VALID && !w_full;
        w_at_last = (r_state == S_IDLE) || r_step || !is_two_step(r_op);
        w_pop     = !HOLD && !w_empty && w_at_last && !w_blocked;
    end

    // Instruction buffer storage (contents are only read behind a non-zero count)
    always_ff @(posedge clk) begin
        if (w_push && !RST) begin
            r_mem[r_wr_ptr] <= instruction;
        end
    end

    // Instruction buffer pointers and occupancy
    always_ff @(posedge clk) begin
        if (RST) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sequencer FSM with registered microword, valid flag and operand address
    always_ff @(posedge clk) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_step      <= 1'b0;
            r_op        <= OP_NOP;
            r_micro     <= NOP_WORD;
            r_mi_valid  <= 1'b0;
            r_data_addr <= {ADDR_W{1'b0}};
`ifdef MI_SEQUENCER_ILLEGAL_TRAP_EN
            r_illegal   <= 1'b0;
`endif
        end else if (HOLD) begin
            r_state     <= r_state;
            r_step      <= r_step;
            r_micro     <= r_micro;
            r_mi_valid  <= r_mi_valid;
            r_data_addr <= r_data_addr;
        end else if (w_pop) begin
            r_op        <= w_head_op;
            r_step      <= 1'b0;
            r_data_addr <= w_head[ADDR_W-1:0];
`ifdef MI_SEQUENCER_ILLEGAL_TRAP_EN
            if (w_head_op == OP_ILL) begin
                r_illegal  <= 1'b1;
                r_state    <= S_IDLE;
                r_mi_valid <= 1'b0;
                r_micro    <= NOP_WORD;
            end else begin
                r_state    <= S_EXEC;
                r_mi_valid <= 1'b1;
                r_micro    <= expand(w_head_op, w_head, 1'b0);
            end
`else
            r_state    <= S_EXEC;
            r_mi_valid <= 1'b1;
            r_micro    <= expand(w_head_op, w_head, 1'b0);
`endif
        end else if ((r_state == S_EXEC) && !w_at_last) begin
            r_step     <= 1'b1;
            r_mi_valid <= 1'b1;
            r_micro    <= expand(r_op, 22'd0, 1'b1);
        end else if (r_state == S_EXEC) begin
            // last step finished with nothing queued: fall back to idle
            r_state    <= S_IDLE;
            r_step     <= 1'b0;
            r_mi_valid <= 1'b0;
            r_micro    <= NOP_WORD;
        end
    end

    assign INSTR_READY       = !w_full;
    assign micro_instruction = r_micro;
    assign MI_VALID          = r_mi_valid;
    assign DATA_ADDR         = r_data_addr;
    assign BUSY              = (r_state == S_EXEC);
`ifdef MI_SEQUENCER_ILLEGAL_TRAP_EN
    assign ILLEGAL           = r_illegal;
`else
    assign ILLEGAL           = 1'b0;
`endif

endmodule

// File: tb/tb_mi_sequencer.sv
// Directed bench for mi_sequencer: hand-computed microwords checked after each rising edge.
module tb_mi_sequencer;

    logic        clk;
    logic        RST;
    logic [21:0] instruction;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic        HOLD;
    logic [32:0] micro_instruction;
    logic        MI_VALID;
    logic [10:0] DATA_ADDR;
    logic        ILLEGAL;
    logic        BUSY;

    int n_pass  = 0;
    int n_total = 0;

    mi_sequencer dut (
        .clk              (clk),
        .RST              (RST),
        .instruction      (instruction),
        .INSTR_VALID      (INSTR_VALID),
        .INSTR_READY      (INSTR_READY),
        .HOLD             (HOLD),
        .micro_instruction(micro_instruction),
        .MI_VALID         (MI_VALID),
        .DATA_ADDR        (DATA_ADDR),
        .ILLEGAL          (ILLEGAL),
        .BUSY             (BUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [32:0] mw(input logic [3:0] alu, input logic kmx, input logic mr, input logic mwr,
                                       input logic [5:0] bb, input logic [5:0] bc, input logic [6:0] t,
                                       input logic [4:0] ba);
        return {alu, 2'b00, kmx, mr, mwr, bb, bc, t, ba};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    logic [32:0] nop_w, jump_w, jze_w, jcy_w, movk_w, adw_w, load0_w, load1_w, store0_w, store1_w;

    initial begin
        nop_w    = mw(4'b1111, 1'b0, 1'b0, 1'b0, 6'b100011, 6'b000000, 7'b0000000, 5'b00000);
        jump_w   = mw(4'b0000, 1'b0, 1'b0, 1'b0, 6'b100010, 6'b100011, 7'b1000000, 5'b00000);
        jze_w    = mw(4'b0000, 1'b0, 1'b0, 1'b0, 6'b100010, 6'b100011, 7'b1000001, 5'b00000);
        jcy_w    = mw(4'b0000, 1'b0, 1'b0, 1'b0, 6'b100010, 6'b100011, 7'b1010000, 5'b00000);
        movk_w   = mw(4'b0000, 1'b1, 1'b0, 1'b0, 6'b100010, 6'b100010, 7'b0000010, 5'b00000);
        adw_w    = mw(4'b0101, 1'b0, 1'b0, 1'b0, 6'b100010, 6'b010101, 7'b0111101, 5'b00011);
        load0_w  = mw(4'b0000, 1'b0, 1'b1, 1'b0, 6'b100010, 6'b100011, 7'b0000000, 5'b00000);
        load1_w  = mw(4'b0000, 1'b0, 1'b0, 1'b0, 6'b100010, 6'b100011, 7'b0000010, 5'b00000);
        store0_w = mw(4'b0000, 1'b0, 1'b0, 1'b0, 6'b100010, 6'b100011, 7'b0000000, 5'b00000);
        store1_w = mw(4'b0000, 1'b0, 1'b0, 1'b1, 6'b100010, 6'b100011, 7'b0000001, 5'b00000);

        RST = 1'b1; HOLD = 1'b0; INSTR_VALID = 1'b0; instruction = 22'h000000;
        tick(); tick();
        RST = 1'b0;
        chk("rst_valid", {63'd0, MI_VALID}, 64'd0);
        chk("rst_busy", {63'd0, BUSY}, 64'd0);
        chk("rst_illegal", {63'd0, ILLEGAL}, 64'd0);
        chk("rst_addr", {53'd0, DATA_ADDR}, 64'd0);
        chk("rst_micro", {31'd0, micro_instruction}, {31'd0, nop_w});
        chk("rst_ready", {63'd0, INSTR_READY}, 64'd1);

        // JUMP into an idle block: valid only after the second edge
        instruction = 22'h200005; INSTR_VALID = 1'b1;
        tick();
        INSTR_VALID = 1'b0;
        chk("jump_no_bypass", {63'd0, MI_VALID}, 64'd0);
        tick();
        chk("jump_valid", {63'd0, MI_VALID}, 64'd1);
        chk("jump_word", {31'd0, micro_instruction}, {31'd0, jump_w});
        chk("jump_addr", {53'd0, DATA_ADDR}, 64'd5);
        chk("jump_busy", {63'd0, BUSY}, 64'd1);
        tick();
        chk("jump_idle_valid", {63'd0, MI_VALID}, 64'd0);
        chk("jump_idle_word", {31'd0, micro_instruction}, {31'd0, nop_w});
        chk("jump_idle_busy", {63'd0, BUSY}, 64'd0);

        // ADW then explicit NOP back to back
        instruction = 22'h1802A3; INSTR_VALID = 1'b1;
        tick();
        instruction = 22'h3F0000;
        tick();
        INSTR_VALID = 1'b0;
        chk("adw_word", {31'd0, micro_instruction}, {31'd0, adw_w});
        chk("adw_addr", {53'd0, DATA_ADDR}, 64'h2A3);
        tick();
        chk("nop_valid", {63'd0, MI_VALID}, 64'd1);
        chk("nop_word", {31'd0, micro_instruction}, {31'd0, nop_w});
        chk("nop_addr", {53'd0, DATA_ADDR}, 64'd0);
        tick();
        chk("nop_idle", {63'd0, MI_VALID}, 64'd0);

        // LOAD then STORE back to back: four consecutive valid words
        instruction = 22'h140003; INSTR_VALID = 1'b1;
        tick();
        instruction = 22'h100007;
        tick();
        INSTR_VALID = 1'b0;
        chk("load0_word", {31'd0, micro_instruction}, {31'd0, load0_w});
        chk("load0_addr", {53'd0, DATA_ADDR}, 64'd3);
        tick();
        chk("load1_valid", {63'd0, MI_VALID}, 64'd1);
        chk("load1_word", {31'd0, micro_instruction}, {31'd0, load1_w});
        chk("load1_addr", {53'd0, DATA_ADDR}, 64'd3);
        tick();
        chk("store0_valid", {63'd0, MI_VALID}, 64'd1);
        chk("store0_word", {31'd0, micro_instruction}, {31'd0, store0_w});
        chk("store0_addr", {53'd0, DATA_ADDR}, 64'd7);
        tick();
        chk("store1_valid", {63'd0, MI_VALID}, 64'd1);
        chk("store1_word", {31'd0, micro_instruction}, {31'd0, store1_w});
        tick();
        chk("ldst_idle", {63'd0, MI_VALID}, 64'd0);

        // Fill the buffer under HOLD, offer one extra word, then drain
        HOLD = 1'b1; INSTR_VALID = 1'b1;
        instruction = 22'h200001; tick();
        instruction = 22'h280002; tick();
        instruction = 22'h380003; tick();
        chk("fill3_ready", {63'd0, INSTR_READY}, 64'd1);
        instruction = 22'h040004; tick();
        chk("full_ready", {63'd0, INSTR_READY}, 64'd0);
        chk("hold_idle_valid", {63'd0, MI_VALID}, 64'd0);
        instruction = 22'h200006; tick();
        chk("full_ready2", {63'd0, INSTR_READY}, 64'd0);
        INSTR_VALID = 1'b0; HOLD = 1'b0;
        tick();
        chk("drain1_word", {31'd0, micro_instruction}, {31'd0, jump_w});
        chk("drain1_addr", {53'd0, DATA_ADDR}, 64'd1);
        chk("drain1_ready", {63'd0, INSTR_READY}, 64'd1);
        tick();
        chk("drain2_word", {31'd0, micro_instruction}, {31'd0, jze_w});
        chk("drain2_addr", {53'd0, DATA_ADDR}, 64'd2);
        tick();
        chk("drain3_word", {31'd0, micro_instruction}, {31'd0, jcy_w});
        chk("drain3_addr", {53'd0, DATA_ADDR}, 64'd3);
        tick();
        chk("drain4_word", {31'd0, micro_instruction}, {31'd0, movk_w});
        chk("drain4_addr", {53'd0, DATA_ADDR}, 64'd4);
        tick();
        chk("drain_extra_dropped", {63'd0, MI_VALID}, 64'd0);

        // HOLD during STORE step1, push while held, then push+pop on one edge
        instruction = 22'h100009; INSTR_VALID = 1'b1;
        tick();
        INSTR_VALID = 1'b0;
        tick();
        tick();
        chk("st_hold_pre", {31'd0, micro_instruction}, {31'd0, store1_w});
        HOLD = 1'b1; instruction = 22'h20000A; INSTR_VALID = 1'b1;
        tick();
        INSTR_VALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("st_hold_word", {31'd0, micro_instruction}, {31'd0, store1_w});
            chk("st_hold_valid", {63'd0, MI_VALID}, 64'd1);
            chk("st_hold_addr", {53'd0, DATA_ADDR}, 64'd9);
            if (i < 2) tick();
        end
        HOLD = 1'b0; instruction = 22'h20000B; INSTR_VALID = 1'b1;
        tick();
        INSTR_VALID = 1'b0;
        chk("pp_a_word", {31'd0, micro_instruction}, {31'd0, jump_w});
        chk("pp_a_addr", {53'd0, DATA_ADDR}, 64'hA);
        tick();
        chk("pp_b_valid", {63'd0, MI_VALID}, 64'd1);
        chk("pp_b_addr", {53'd0, DATA_ADDR}, 64'hB);
        tick();
        chk("pp_empty", {63'd0, MI_VALID}, 64'd0);

        // Reset during LOAD step0 abandons the instruction
        instruction = 22'h140005; INSTR_VALID = 1'b1;
        tick();
        INSTR_VALID = 1'b0;
        tick();
        chk("rl_load0", {31'd0, micro_instruction}, {31'd0, load0_w});
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rl_valid", {63'd0, MI_VALID}, 64'd0);
        chk("rl_word", {31'd0, micro_instruction}, {31'd0, nop_w});
        chk("rl_busy", {63'd0, BUSY}, 64'd0);
        tick();
        chk("rl_no_step1", {63'd0, MI_VALID}, 64'd0);
        chk("rl_ready", {63'd0, INSTR_READY}, 64'd1);
        tick();
        chk("rl_empty", {63'd0, MI_VALID}, 64'd0);

        // Illegal opcode followed by a queued JUMP
        instruction = 22'h000001; INSTR_VALID = 1'b1;
        tick();
        instruction = 22'h20000C;
        tick();
        INSTR_VALID = 1'b0;
`ifdef MI_SEQUENCER_ILLEGAL_TRAP_EN
        chk("ill_valid", {63'd0, MI_VALID}, 64'd0);
        chk("ill_word", {31'd0, micro_instruction}, {31'd0, nop_w});
        chk("ill_flag", {63'd0, ILLEGAL}, 64'd1);
        tick();
        chk("ill_blocked_valid", {63'd0, MI_VALID}, 64'd0);
        chk("ill_blocked_addr", {53'd0, DATA_ADDR}, 64'd1);
        chk("ill_sticky", {63'd0, ILLEGAL}, 64'd1);
        tick();
        chk("ill_sticky2", {63'd0, ILLEGAL}, 64'd1);
        chk("ill_blocked2", {63'd0, MI_VALID}, 64'd0);
`else
        chk("ill_valid", {63'd0, MI_VALID}, 64'd1);
        chk("ill_word", {31'd0, micro_instruction}, {31'd0, nop_w});
        chk("ill_flag", {63'd0, ILLEGAL}, 64'd0);
        chk("ill_addr", {53'd0, DATA_ADDR}, 64'd1);
        tick();
        chk("ill_next_word", {31'd0, micro_instruction}, {31'd0, jump_w});
        chk("ill_next_addr", {53'd0, DATA_ADDR}, 64'hC);
        chk("ill_flag2", {63'd0, ILLEGAL}, 64'd0);
        tick();
        chk("ill_done", {63'd0, MI_VALID}, 64'd0);
`endif
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("final_rst_illegal", {63'd0, ILLEGAL}, 64'd0);
        chk("final_rst_ready", {63'd0, INSTR_READY}, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000 ns");
        $fatal(1, "timeout");
    end

endmodule
